// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot decoder with enable, polarity select and auto-scan
//
// Purpose: SEL_W-to-2^SEL_W registered decoder. In direct mode it decodes sel;
// in scan mode a prescaled counter walks the active output through 0..NUM_OUT-1.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high
//   en    in   enable; low forces all outputs inactive and freezes scan state
//   mode  in   0 = direct decode of sel, 1 = auto-scan
//   sel   in   [SEL_W-1:0] direct select / scan load value
//   load  in   scan mode: load sel into the index
//   out   out  [2^SEL_W-1:0] decoded outputs, registered
//   idx   out  [SEL_W-1:0] current index, registered
//   wrap  out  one-clock pulse when the scan index wraps back to 0
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int NO = 2 ** SEL_W;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SEL_W:0]   NUM_V = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [PW-1:0]    PTERM = PW'(DIV - 1);
  localparam logic [NO-1:0]    INACT = (ACTIVE_LOW != 0) ? {NO{1'b1}} : {NO{1'b0}};

  logic [PW-1:0]    presc, presc_n;
  logic             mode_q, mode_n;
  logic [SEL_W-1:0] idx_n;
  logic             wrap_n;
  logic [NO-1:0]    out_n;

  // Indices beyond NUM_OUT decode to all-inactive.
  function automatic logic [NO-1:0] decode(input logic [SEL_W-1:0] i);
    logic [NO-1:0] v;
    v = '0;
    if ({1'b0, i} < NUM_V) v[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  function automatic logic [SEL_W-1:0] clamp(input logic [SEL_W-1:0] i);
    return ({1'b0, i} < NUM_V) ? i : '0;
  endfunction

  always_comb begin
    idx_n   = idx;
    presc_n = presc;
    mode_n  = mode_q;
    wrap_n  = 1'b0;
    out_n   = INACT;
    if (en) begin
      if (!mode) begin
        idx_n   = sel;
        presc_n = '0;
        mode_n  = 1'b0;
      end else if (load) begin
        idx_n   = clamp(sel);
        presc_n = '0;
        mode_n  = 1'b1;
      end else if (!mode_q) begin
        // First scan edge after direct mode: restart the step period from here.
        idx_n   = clamp(idx);
        presc_n = '0;
        mode_n  = 1'b1;
      end else if (presc == PTERM) begin
        presc_n = '0;
        if (idx >= LAST) begin
          idx_n  = '0;
          wrap_n = 1'b1;
        end else begin
          idx_n = idx + SEL_W'(1);
        end
      end else begin
        presc_n = presc + PW'(1);
      end
      out_n = decode(idx_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      presc  <= '0;
      mode_q <= 1'b0;
      wrap   <= 1'b0;
      out    <= INACT;
    end else begin
      idx    <= idx_n;
      presc  <= presc_n;
      mode_q <= mode_n;
      wrap   <= wrap_n;
      out    <= out_n;
    end
  end

endmodule
